// File: rtl/packet_deframer.sv
// Reassembles three-word serial frames (header, addr, data) into a parallel packet.
// Malformed frames are dropped, flagged with a one-cycle error pulse and counted.
module packet_deframer #(
    parameter int          WIDTH = 16,
    parameter logic [3:0]  SYNC  = 4'hA,
    parameter int          ERR_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_bits,
    input  logic             io_in_last,
    output logic             io_outPacket_valid,
    input  logic             io_outPacket_ready,
    output logic [WIDTH-1:0] io_outPacket_header,
    output logic [WIDTH-1:0] io_outPacket_addr,
    output logic [WIDTH-1:0] io_outPacket_data,
    output logic             io_error,
    output logic [ERR_W-1:0] io_errCount
);

    typedef enum logic [2:0] {
        S_HDR,
        S_ADDR,
        S_DATA,
        S_OUT,
        S_FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] header_q, header_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             error_q;
    logic [ERR_W-1:0] errCount_q;
    logic             errPulse;
    logic             inFire;
    logic             outFire;
    logic             syncOk;

    assign io_in_ready         = (state_q != S_OUT);
    assign io_outPacket_valid  = (state_q == S_OUT);
    assign inFire              = io_in_valid && io_in_ready;
    assign outFire             = io_outPacket_valid && io_outPacket_ready;
    assign syncOk              = (io_in_bits[WIDTH-1:WIDTH-4] == SYNC);
    assign io_outPacket_header = header_q;
    assign io_outPacket_addr   = addr_q;
    assign io_outPacket_data   = data_q;
    assign io_error            = error_q;
    assign io_errCount         = errCount_q;

    always_comb begin
        state_d  = state_q;
        header_d = header_q;
        addr_d   = addr_q;
        data_d   = data_q;
        errPulse = 1'b0;
        unique case (state_q)
            S_HDR: begin
                if (inFire) begin
                    if (!syncOk || io_in_last) begin
                        errPulse = 1'b1;
                        state_d  = io_in_last ? S_HDR : S_FLUSH;
                    end else begin
                        header_d = io_in_bits;
                        state_d  = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                // A stale header left behind by a short frame is harmless: it is
                // only ever presented after a fresh header overwrites it.
                if (inFire) begin
                    if (io_in_last) begin
                        errPulse = 1'b1;
                        state_d  = S_HDR;
                    end else begin
                        addr_d  = io_in_bits;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (inFire) begin
                    if (!io_in_last) begin
                        errPulse = 1'b1;
                        state_d  = S_FLUSH;
                    end else begin
                        data_d  = io_in_bits;
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (outFire) begin
                    state_d = S_HDR;
                end
            end
            S_FLUSH: begin
                if (inFire && io_in_last) begin
                    state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_HDR;
            header_q   <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            error_q    <= 1'b0;
            errCount_q <= '0;
        end else begin
            state_q  <= state_d;
            header_q <= header_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            error_q  <= errPulse;
            // Saturate rather than wrap so a flood of bad frames stays visible.
            if (errPulse && (errCount_q != {ERR_W{1'b1}})) begin
                errCount_q <= errCount_q + {{(ERR_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_packet_deframer.sv
// Self-checking bench for packet_deframer: directed vector table, hand-written
// corner sequences, and a randomized run against a frame-level reference model.
module tb_packet_deframer;

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [15:0] inBits;
    logic        inLast;
    logic        outValid;
    logic        outReady;
    logic [15:0] outHeader;
    logic [15:0] outAddr;
    logic [15:0] outData;
    logic        errorPulse;
    logic [7:0]  errCount;

    int assertCount = 0;
    int failCount   = 0;

    packet_deframer #(.WIDTH(16), .SYNC(4'hA), .ERR_W(8)) dut (
        .clock               (clock),
        .reset               (reset),
        .io_in_valid         (inValid),
        .io_in_ready         (inReady),
        .io_in_bits          (inBits),
        .io_in_last          (inLast),
        .io_outPacket_valid  (outValid),
        .io_outPacket_ready  (outReady),
        .io_outPacket_header (outHeader),
        .io_outPacket_addr   (outAddr),
        .io_outPacket_data   (outData),
        .io_error            (errorPulse),
        .io_errCount         (errCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [15:0] bits;
        logic        last;
        logic        rdy;
        logic        eValid;
        logic        eErr;
        logic [7:0]  eCnt;
        logic        eInRdy;
        logic [15:0] eHdr;
        logic [15:0] eAddr;
        logic [15:0] eData;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: words of the frame in progress, whether it has
    // already been rejected, and the packet waiting to be consumed.
    logic [15:0] frameQ[$];
    logic        frameBad;
    logic        mPending;
    logic [15:0] mHdr, mAddr, mData;
    logic        mErr;
    int          mCnt;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the clock edge happen, return at the next negedge.
    task automatic applyStimulus(input logic v, input logic [15:0] b, input logic l, input logic r);
        inValid  = v;
        inBits   = b;
        inLast   = l;
        outReady = r;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, 32'(outValid), 32'd0);
        checkOutput({tag, "_error"}, 32'(errorPulse), 32'd0);
        checkOutput({tag, "_count"}, 32'(errCount), 32'd0);
        checkOutput({tag, "_inReady"}, 32'(inReady), 32'd1);
    endtask

    task automatic checkPacket(input string tag, input logic [15:0] h, input logic [15:0] a, input logic [15:0] d);
        checkOutput({tag, "_valid"}, 32'(outValid), 32'd1);
        checkOutput({tag, "_header"}, 32'(outHeader), 32'(h));
        checkOutput({tag, "_addr"}, 32'(outAddr), 32'(a));
        checkOutput({tag, "_data"}, 32'(outData), 32'(d));
    endtask

    // One clock of the reference model, written in terms of frame positions.
    task automatic modelStep(input logic v, input logic [15:0] b, input logic l, input logic r);
        int  idx;
        logic bad;
        mErr = 1'b0;
        if (mPending) begin
            if (r) mPending = 1'b0;
        end else if (v) begin
            idx = frameQ.size();
            if (!frameBad) begin
                bad = (idx == 0 && (b[15:12] != 4'hA || l)) ||
                      (idx == 1 && l) ||
                      (idx == 2 && !l);
                if (bad) begin
                    frameBad = 1'b1;
                    mErr     = 1'b1;
                    if (mCnt < 255) mCnt++;
                end else begin
                    frameQ.push_back(b);
                end
            end
            if (l) begin
                if (!frameBad && frameQ.size() == 3) begin
                    mPending = 1'b1;
                    mHdr     = frameQ[0];
                    mAddr    = frameQ[1];
                    mData    = frameQ[2];
                end
                frameQ.delete();
                frameBad = 1'b0;
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        inValid  = 1'b0;
        inBits   = 16'h0;
        inLast   = 1'b0;
        outReady = 1'b0;
        @(negedge clock);
        doReset();

        // Reset state
        checkIdle("reset");
        checkOutput("reset_header", 32'(outHeader), 32'd0);
        checkOutput("reset_addr", 32'(outAddr), 32'd0);
        checkOutput("reset_data", 32'(outData), 32'd0);

        // Directed table: good frame, bad sync, short, long, single-word, good again
        vecs.push_back('{1'b1, 16'hA123, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 16'h0, 16'h0, 16'h0});
        vecs.push_back('{1'b1, 16'h0040, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 16'h0, 16'h0, 16'h0});
        vecs.push_back('{1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 16'hA123, 16'h0040, 16'hBEEF});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 16'h0, 16'h0, 16'h0});
        vecs.push_back('{1'b1, 16'h5123, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 16'h0, 16'h0, 16'h0});
        vecs.push_back('{1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 16'h0, 16'h0, 16'h0});
        vecs.push_back('{1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 16'h0, 16'h0, 16'h0});
        vecs.push_back('{1'b1, 16'hA000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 16'h0, 16'h0, 16'h0});
        vecs.push_back('{1'b1, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 1'b1, 16'h0, 16'h0, 16'h0});
        vecs.push_back('{1'b1, 16'hA000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 16'h0, 16'h0, 16'h0});
        vecs.push_back('{1'b1, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 16'h0, 16'h0, 16'h0});
        vecs.push_back('{1'b1, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 16'h0, 16'h0, 16'h0});
        vecs.push_back('{1'b1, 16'h0030, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 16'h0, 16'h0, 16'h0});
        vecs.push_back('{1'b1, 16'hA111, 1'b1, 1'b1, 1'b0, 1'b1, 8'd4, 1'b1, 16'h0, 16'h0, 16'h0});
        vecs.push_back('{1'b1, 16'hAFFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 16'h0, 16'h0, 16'h0});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 16'h0, 16'h0, 16'h0});
        vecs.push_back('{1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 16'h0, 16'h0, 16'h0});
        vecs.push_back('{1'b1, 16'h5678, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4, 1'b0, 16'hAFFF, 16'h1234, 16'h5678});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 16'h0, 16'h0, 16'h0});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].v, vecs[i].bits, vecs[i].last, vecs[i].rdy);
            checkOutput($sformatf("vec%0d_valid", i), 32'(outValid), 32'(vecs[i].eValid));
            checkOutput($sformatf("vec%0d_error", i), 32'(errorPulse), 32'(vecs[i].eErr));
            checkOutput($sformatf("vec%0d_count", i), 32'(errCount), 32'(vecs[i].eCnt));
            checkOutput($sformatf("vec%0d_inReady", i), 32'(inReady), 32'(vecs[i].eInRdy));
            if (vecs[i].eValid) begin
                checkPacket($sformatf("vec%0d", i), vecs[i].eHdr, vecs[i].eAddr, vecs[i].eData);
            end
        end

        // Backpressure: packet held for 5 cycles while the next header waits
        doReset();
        applyStimulus(1'b1, 16'hA123, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0);
        checkPacket("bp_first", 16'hA123, 16'h0040, 16'hBEEF);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 16'hA777, 1'b0, 1'b0);
            checkPacket($sformatf("bp_hold%0d", c), 16'hA123, 16'h0040, 16'hBEEF);
            checkOutput($sformatf("bp_hold%0d_inReady", c), 32'(inReady), 32'd0);
        end
        applyStimulus(1'b1, 16'hA777, 1'b0, 1'b1);
        checkOutput("bp_release_valid", 32'(outValid), 32'd0);
        checkOutput("bp_release_inReady", 32'(inReady), 32'd1);
        applyStimulus(1'b1, 16'hA777, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0002, 1'b1, 1'b1);
        checkPacket("bp_second", 16'hA777, 16'h0001, 16'h0002);
        checkOutput("bp_second_count", 32'(errCount), 32'd0);

        // Saturation: 300 single-word frames, each rejected
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        for (int n = 1; n <= 300; n++) begin
            applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1);
            checkOutput($sformatf("sat%0d_error", n), 32'(errorPulse), 32'd1);
            checkOutput($sformatf("sat%0d_count", n), 32'(errCount), (n < 255) ? 32'(n) : 32'd255);
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("sat_idle_error", 32'(errorPulse), 32'd0);
        checkOutput("sat_idle_count", 32'(errCount), 32'd255);

        // Reset mid-frame after header and addr are accepted
        applyStimulus(1'b1, 16'hA123, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0040, 1'b0, 1'b1);
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        reset = 1'b0;
        checkIdle("midreset");
        checkOutput("midreset_header", 32'(outHeader), 32'd0);
        checkOutput("midreset_addr", 32'(outAddr), 32'd0);
        applyStimulus(1'b1, 16'hA9A9, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0102, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0304, 1'b1, 1'b1);
        checkPacket("midreset_after", 16'hA9A9, 16'h0102, 16'h0304);
        checkOutput("midreset_after_count", 32'(errCount), 32'd0);

        // Randomized traffic against the reference model
        doReset();
        frameQ.delete();
        frameBad = 1'b0;
        mPending = 1'b0;
        mHdr = 16'h0; mAddr = 16'h0; mData = 16'h0;
        mErr = 1'b0;
        mCnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        rv, rl, rr;
            logic [15:0] rb;
            checkOutput("rnd_valid", 32'(outValid), 32'(mPending));
            checkOutput("rnd_inReady", 32'(inReady), 32'(!mPending));
            checkOutput("rnd_error", 32'(errorPulse), 32'(mErr));
            checkOutput("rnd_count", 32'(errCount), 32'(mCnt));
            if (mPending) checkPacket("rnd", mHdr, mAddr, mData);
            rv = ($urandom_range(0, 9) < 7);
            rl = ($urandom_range(0, 9) < 4);
            rr = ($urandom_range(0, 9) < 5);
            rb = 16'($urandom);
            if ($urandom_range(0, 9) < 8) rb[15:12] = 4'hA;
            modelStep(rv, rb, rl, rr);
            applyStimulus(rv, rb, rl, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
